// File: rtl/hwag_coil_scheduler.sv
// Angle-synchronous ignition coil scheduler: per-channel angle counters, shared
// charge/ignition set points, OFF/ON dwell FSM with sticky dwell-overrun fault.
module hwag_coil_scheduler #(
    parameter int CH      = 4,
    parameter int AW      = 24,
    parameter int ACR_TOP = 3839
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            acnt_ena,
    input  logic            hwag_start,
    input  logic            edge0,
    input  logic [CH*AW-1:0] phase_ofs,
    input  logic [AW-1:0]   charge_angle,
    input  logic [AW-1:0]   ignition_angle,
    input  logic [AW-1:0]   max_dwell,
    input  logic [CH-1:0]   ch_enable,
    input  logic            fault_clr,
    output logic [CH-1:0]   coil_out,
    output logic [CH-1:0]   ch_fault
);

    typedef enum logic {ST_OFF = 1'b0, ST_ON = 1'b1} state_t;

    localparam logic [AW-1:0] TOP      = AW'(ACR_TOP);
    localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ZERO     = {AW{1'b0}};
    localparam logic [AW-1:0] DW_SAT   = {AW{1'b1}};

    logic [AW-1:0] cnt_q   [CH];
    logic [AW-1:0] cnt_d   [CH];
    logic [AW-1:0] dwell_q [CH];
    logic [AW-1:0] dwell_d [CH];
    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [AW-1:0] chg_q, chg_d, ign_q, ign_d;
    logic [CH-1:0] fault_q, fault_d;
    logic [CH-1:0] chg_hit_s, ign_hit_s, overrun_s, fault_set_s;

    // Shared set-point shadow commit
    always_comb begin
        chg_d = chg_q;
        ign_d = ign_q;
        if (edge0) begin
            chg_d = charge_angle;
            ign_d = ignition_angle;
        end else begin
            chg_d = chg_q;
            ign_d = ign_q;
        end
    end

    // Compare against pre-increment counters; set points beyond the top never match
    always_comb begin
        for (int n = 0; n < CH; n++) begin
            chg_hit_s[n] = acnt_ena && (cnt_q[n] == chg_q) && (chg_q <= TOP);
            ign_hit_s[n] = acnt_ena && (cnt_q[n] == ign_q) && (ign_q <= TOP);
            overrun_s[n] = acnt_ena && (max_dwell != ZERO) && (dwell_q[n] == max_dwell);
        end
    end

    // Per-channel counter, dwell and OFF/ON next state
    always_comb begin
        for (int n = 0; n < CH; n++) begin
            cnt_d[n]       = cnt_q[n];
            dwell_d[n]     = dwell_q[n];
            state_d[n]     = state_q[n];
            fault_set_s[n] = 1'b0;

            if (!hwag_start) begin
                cnt_d[n] = phase_ofs[n*AW +: AW];
            end else if (acnt_ena) begin
                cnt_d[n] = (cnt_q[n] == TOP) ? ZERO : cnt_q[n] + ONE;
            end else begin
                cnt_d[n] = cnt_q[n];
            end

            if (!ch_enable[n] || !hwag_start) begin
                state_d[n] = ST_OFF;
            end else begin
                case (state_q[n])
                    ST_OFF: begin
                        if (chg_hit_s[n] && !ign_hit_s[n]) begin
                            state_d[n] = ST_ON;
                            dwell_d[n] = ZERO;
                        end else begin
                            state_d[n] = ST_OFF;
                        end
                    end
                    ST_ON: begin
                        // Ignition takes priority so a coincident overrun is not a fault
                        if (ign_hit_s[n]) begin
                            state_d[n] = ST_OFF;
                        end else if (overrun_s[n]) begin
                            state_d[n]     = ST_OFF;
                            fault_set_s[n] = 1'b1;
                        end else if (acnt_ena && (dwell_q[n] != DW_SAT)) begin
                            dwell_d[n] = dwell_q[n] + ONE;
                        end else begin
                            dwell_d[n] = dwell_q[n];
                        end
                    end
                    default: begin
                        state_d[n] = ST_OFF;
                    end
                endcase
            end
        end
    end

    // Sticky faults: a new fault outranks a simultaneous clear
    always_comb begin
        if (fault_clr) begin
            fault_d = fault_set_s;
        end else begin
            fault_d = fault_q | fault_set_s;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            chg_q   <= ZERO;
            ign_q   <= ZERO;
            fault_q <= {CH{1'b0}};
            for (int n = 0; n < CH; n++) begin
                cnt_q[n]   <= ZERO;
                dwell_q[n] <= ZERO;
                state_q[n] <= ST_OFF;
            end
        end else begin
            chg_q   <= chg_d;
            ign_q   <= ign_d;
            fault_q <= fault_d;
            for (int n = 0; n < CH; n++) begin
                cnt_q[n]   <= cnt_d[n];
                dwell_q[n] <= dwell_d[n];
                state_q[n] <= state_d[n];
            end
        end
    end

    // Coil drive is the registered ON state
    always_comb begin
        for (int n = 0; n < CH; n++) begin
            coil_out[n] = (state_q[n] == ST_ON);
        end
    end

    assign ch_fault = fault_q;

endmodule

// File: doc/hwag_coil_scheduler.md
HWAG_COIL_SCHEDULER -- requirements
Module: hwag_coil_scheduler

Interface
REQ-001 SHALL have parameter CH, default 4: number of coil channels, 1..8.
REQ-002 SHALL have parameter AW, default 24: angle counter and set-point width.
REQ-003 SHALL have parameter ACR_TOP, default 3839: last angle count before wrap to 0.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port acnt_ena  input  1  angle tick strobe from master angle counter.
REQ-007 SHALL have port hwag_start  input  1  master synchronised; low = hold and reload phase offsets.
REQ-008 SHALL have port edge0  input  1  set-point commit strobe.
REQ-009 SHALL have port phase_ofs  input  CH*AW  per-channel counter load value, channel n at bits [n*AW +: AW].
REQ-010 SHALL have port charge_angle  input  AW  shadow charge (coil-on) angle.
REQ-011 SHALL have port ignition_angle  input  AW  shadow ignition (coil-off) angle.
REQ-012 SHALL have port max_dwell  input  AW  dwell limit in angle ticks; 0 disables the limit.
REQ-013 SHALL have port ch_enable  input  CH  per-channel enable.
REQ-014 SHALL have port fault_clr  input  1  clears all fault flags.
REQ-015 SHALL have port coil_out  output  CH  registered coil drive, 1 = charging.
REQ-016 SHALL have port ch_fault  output  CH  sticky dwell-overrun flag per channel.

Function
REQ-017 Each channel SHALL own an AW-bit angle counter: hwag_start low -> load phase_ofs[n]; else on acnt_ena -> increment; at ACR_TOP with acnt_ena -> 0.
REQ-018 Active charge/ignition registers SHALL load from charge_angle/ignition_angle on edge0; they are shared by all channels and hold otherwise.
REQ-019 Match SHALL be defined as acnt_ena high and the pre-increment counter equal to the active set point; set points above ACR_TOP never match.
REQ-020 Each channel SHALL run FSM OFF/ON; OFF -> ON on charge match; ON -> OFF on ignition match or dwell overrun.
REQ-021 Charge and ignition match in the same cycle while OFF SHALL leave the channel OFF, zero dwell.
REQ-022 A charge match while ON SHALL be ignored; dwell count SHALL continue.
REQ-023 Dwell counter SHALL clear on OFF -> ON and increment per acnt_ena while ON, saturating at all-ones.
REQ-024 When max_dwell != 0 and the dwell counter equals max_dwell with acnt_ena while ON: -> OFF and set ch_fault[n], same cycle.
REQ-025 Ignition match and dwell overrun in the same cycle SHALL go OFF without setting the fault.
REQ-026 ch_enable[n] low or hwag_start low SHALL force the channel OFF next cycle; the channel resumes at OFF and waits for a fresh charge match.
REQ-027 A charge angle greater than the ignition angle SHALL be legal; dwell wraps through 0 with no special handling.
REQ-028 coil_out[n] SHALL be 1 exactly when the channel state is ON, with 1-cycle latency from the triggering acnt_ena cycle.
REQ-029 fault_clr SHALL clear all ch_fault bits; a fault set in the same cycle wins.
REQ-030 An edge0 commit mid-dwell SHALL take effect on the next compare; no glitch or retrigger SHALL result.

Reset
REQ-031 With nrst low at a clock edge: counters 0, active set points 0, dwell counters 0, states OFF, coil_out 0, ch_fault 0.
REQ-032 Reset SHALL override all other inputs, including mid-dwell; coil_out SHALL drop on the first reset edge.

Verification
REQ-033 CH=2, phase_ofs {832,2752}, hwag_start low then high, 3840 acnt_ena ticks -> ch0 passes 0 after 3008 ticks and ch1 after 1088; both wrap 3839 -> 0.
REQ-034 charge 100, ignition 200, max_dwell 0, edge0 pulse -> coil_out[0] high 1 cycle after the tick at count 100, low 1 cycle after the tick at 200, 100 ticks of dwell.
REQ-035 charge 3800, ignition 40 -> coil on at 3800, stays high across the wrap, off at 40, 80 ticks; no fault.
REQ-036 charge 100, ignition 300, max_dwell 50 -> coil off after 50 ticks, ch_fault[0]=1 and held; fault_clr pulse -> 0.
REQ-037 charge = ignition = 500 -> coil_out stays 0; hwag_start dropped mid-dwell -> coil_out 0 next cycle; nrst low mid-dwell -> all outputs 0.
